// File: rtl/subtractor_seq_chunked_pkg.sv
// rtl/subtractor_seq_chunked_pkg.sv - shared types and helpers for the chunked subtractor
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } sub_state_t;

    function automatic int nchunk_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index needs at least one bit even when there is a single chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/subtractor_seq_chunked_sub_chunk.sv
// rtl/subtractor_seq_chunked_sub_chunk.sv - combinational CHUNK-bit subtract with borrow in/out
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    // The extra MSB of the widened difference is the borrow out.
    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/subtractor_seq_chunked.sv
// rtl/subtractor_seq_chunked.sv - multi-cycle a-b-bin, CHUNK bits per clock; SUB_OVF_FLAG_EN adds ovf
module subtractor_seq_chunked
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SUB_OVF_FLAG_EN
    ,output logic            ovf
`endif
);

    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    sub_state_t       state;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic             nonzero;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] c_diff;
    logic             c_bout;

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_c = a_q[i*CHUNK +: CHUNK];
                b_c = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_c),
        .b    (b_c),
        .bin  (borrow),
        .diff (c_diff),
        .bout (c_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            borrow    <= 1'b0;
            nonzero   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow   <= bin;
                        idx      <= '0;
                        nonzero  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx == IW'(i)) begin
                            diff[i*CHUNK +: CHUNK] <= c_diff;
                        end
                    end
                    borrow  <= c_bout;
                    nonzero <= nonzero | (|c_diff);
                    if (idx == LAST) begin
                        // Flags come from the final chunk directly; diff's top slice is not yet visible.
                        bout      <= c_bout;
                        zero      <= ~(nonzero | (|c_diff));
`ifdef SUB_OVF_FLAG_EN
                        ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ c_diff[CHUNK-1]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
